// File: rtl/curl_pow_ctrl_pkg.sv
// Shared constants, FSM state type and the MWM mask helper for the Curl PoW job sequencer.
package curl_pow_pkg;

  localparam int DATA_WIDTH        = 54;
  localparam int WORDS_PER_BLOCK   = 9;
  localparam int NONCE_WORD_OFFSET = 6;
  localparam int NONCE_WORDS       = 3;
  localparam int MWM_MASK_WIDTH    = 32;
  localparam int BLK_CNT_WIDTH     = 4;
  localparam int MWM_WIDTH         = 6;
  localparam int CORE_ADDR_WIDTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFORM_REQ,
    ST_XFORM_WAIT,
    ST_POW_REQ,
    ST_POW_WAIT,
    ST_NONCE_OUT
  } state_t;

  // Top mwm bits set; values of 32 and above give an all-ones mask.
  function automatic logic [MWM_MASK_WIDTH-1:0] mwm_to_mask(input logic [MWM_WIDTH-1:0] mwm);
    if (mwm >= MWM_WIDTH'(MWM_MASK_WIDTH)) return '1;
    return ~({MWM_MASK_WIDTH{1'b1}} >> mwm);
  endfunction

endpackage

// File: rtl/curl_pow_ctrl_if.sv
// Word-in / nonce-out streams between the HPS-side bridge (master) and the sequencer (slave).
// Both streams use valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// a source holds data stable while valid is high and ready is low.
interface curl_pow_ctrl_if import curl_pow_pkg::*; ();

  logic [DATA_WIDTH-1:0] i_s_data;
  logic                  i_s_valid;
  logic                  o_s_ready;
  logic [DATA_WIDTH-1:0] o_m_data;
  logic                  o_m_valid;
  logic                  o_m_last;
  logic                  i_m_ready;

  modport master (
    output i_s_data, i_s_valid, i_m_ready,
    input  o_s_ready, o_m_data, o_m_valid, o_m_last
  );

  modport slave (
    input  i_s_data, i_s_valid, i_m_ready,
    output o_s_ready, o_m_data, o_m_valid, o_m_last
  );

endinterface

// File: rtl/curl_pow_ctrl.sv
// Job sequencer for the Curl PoW core: absorbs blocks, launches PoW, streams back the nonce.
// Optional macro CURL_POW_CTRL_ATTEMPT_CNT_EN adds a full 32-bit o_attempts counter output.
module curl_pow_ctrl import curl_pow_pkg::*; (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [BLK_CNT_WIDTH-1:0]   i_num_blocks,
  input  logic [MWM_WIDTH-1:0]       i_mwm,
  curl_pow_ctrl_if.slave             strm,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic                       o_core_we,
  output logic [CORE_ADDR_WIDTH-1:0] o_core_addr,
  output logic [DATA_WIDTH-1:0]      o_core_data,
  output logic                       o_core_transform,
  output logic                       o_core_pow,
  output logic [MWM_MASK_WIDTH-1:0]  o_core_mwm_mask,
  input  logic                       i_core_transforming,
  input  logic                       i_core_pow_hash_finish,
  input  logic                       i_core_pow_finish,
  input  logic [DATA_WIDTH-1:0]      i_core_data,
`ifdef CURL_POW_CTRL_ATTEMPT_CNT_EN
  output logic [31:0]                o_attempts,
`endif
  output state_t                     o_dbg_state
);

`ifdef CURL_POW_CTRL_ATTEMPT_CNT_EN
  localparam int ATT_W = 32;
  localparam logic [ATT_W-1:0] ATT_MAX = '1;
`else
  localparam int ATT_W = 2;
  localparam logic [ATT_W-1:0] ATT_MAX = 2'd2;
`endif

  state_t                      state_q, state_d;
  logic [BLK_CNT_WIDTH-1:0]    blks_q, blk_cnt_q;
  logic [CORE_ADDR_WIDTH-1:0]  word_cnt_q;
  logic [1:0]                  idx_q;
  logic                        seen_busy_q;
  logic [DATA_WIDTH-1:0]       nonce_cap_q [NONCE_WORDS];
  logic [MWM_MASK_WIDTH-1:0]   mask_q;
  logic                        err_q, done_q;
  logic [ATT_W-1:0]            att_q;

  logic params_ok, last_blk, s_beat, last_word, m_accept_last;
  logic [DATA_WIDTH-1:0] m_data;

  assign params_ok     = (i_num_blocks != '0) && (i_mwm <= MWM_WIDTH'(MWM_MASK_WIDTH));
  assign last_blk      = (blk_cnt_q == blks_q - BLK_CNT_WIDTH'(1));
  assign s_beat        = (state_q == ST_LOAD) && strm.i_s_valid;
  assign last_word     = (word_cnt_q == CORE_ADDR_WIDTH'(WORDS_PER_BLOCK - 1));
  assign m_accept_last = (state_q == ST_NONCE_OUT) && strm.i_m_ready && (idx_q == 2'd2);

  // A single successful attempt means the host-supplied nonce words were the winners.
  assign m_data = (att_q == ATT_W'(1)) ? nonce_cap_q[idx_q] : i_core_data;

  always_comb begin
    state_d          = state_q;
    strm.o_s_ready   = 1'b0;
    strm.o_m_valid   = 1'b0;
    strm.o_m_last    = 1'b0;
    strm.o_m_data    = '0;
    o_core_we        = 1'b0;
    o_core_addr      = '0;
    o_core_data      = '0;
    o_core_transform = 1'b0;
    o_core_pow       = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start && params_ok) state_d = ST_LOAD;
      ST_LOAD: begin
        strm.o_s_ready = 1'b1;
        if (strm.i_s_valid) begin
          o_core_we   = 1'b1;
          o_core_addr = word_cnt_q;
          o_core_data = strm.i_s_data;
          if (last_word) state_d = last_blk ? ST_POW_REQ : ST_XFORM_REQ;
        end
      end
      ST_XFORM_REQ: begin
        o_core_transform = 1'b1;
        state_d          = ST_XFORM_WAIT;
      end
      // Wait for a full busy high-then-low cycle; transform latency is not assumed.
      ST_XFORM_WAIT: if (seen_busy_q && !i_core_transforming) state_d = ST_LOAD;
      ST_POW_REQ: begin
        o_core_pow = 1'b1;
        state_d    = ST_POW_WAIT;
      end
      ST_POW_WAIT: if (i_core_pow_finish) state_d = ST_NONCE_OUT;
      ST_NONCE_OUT: begin
        strm.o_m_valid = 1'b1;
        strm.o_m_last  = (idx_q == 2'd2);
        strm.o_m_data  = m_data;
        o_core_addr    = CORE_ADDR_WIDTH'(idx_q);
        if (m_accept_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      blks_q      <= '0;
      blk_cnt_q   <= '0;
      word_cnt_q  <= '0;
      idx_q       <= '0;
      seen_busy_q <= 1'b0;
      mask_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      att_q       <= '0;
      for (int i = 0; i < NONCE_WORDS; i++) nonce_cap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == ST_IDLE) && i_start && !params_ok;
      done_q  <= m_accept_last;
      case (state_q)
        ST_IDLE: if (i_start && params_ok) begin
          blks_q     <= i_num_blocks;
          mask_q     <= mwm_to_mask(i_mwm);
          blk_cnt_q  <= '0;
          word_cnt_q <= '0;
          att_q      <= '0;
        end
        ST_LOAD: if (s_beat) begin
          word_cnt_q <= last_word ? '0 : word_cnt_q + CORE_ADDR_WIDTH'(1);
          if (last_blk && (word_cnt_q >= CORE_ADDR_WIDTH'(NONCE_WORD_OFFSET)))
            nonce_cap_q[2'(word_cnt_q - CORE_ADDR_WIDTH'(NONCE_WORD_OFFSET))] <= strm.i_s_data;
        end
        ST_XFORM_REQ: seen_busy_q <= 1'b0;
        ST_XFORM_WAIT: begin
          if (i_core_transforming) seen_busy_q <= 1'b1;
          else if (seen_busy_q)    blk_cnt_q   <= blk_cnt_q + BLK_CNT_WIDTH'(1);
        end
        ST_POW_WAIT: begin
          if (i_core_pow_hash_finish && (att_q != ATT_MAX)) att_q <= att_q + ATT_W'(1);
          if (i_core_pow_finish) idx_q <= '0;
        end
        ST_NONCE_OUT: if (strm.i_m_ready) idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        default: ;
      endcase
    end
  end

  assign o_busy          = (state_q != ST_IDLE);
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_core_mwm_mask = mask_q;
  assign o_dbg_state     = state_q;
`ifdef CURL_POW_CTRL_ATTEMPT_CNT_EN
  assign o_attempts      = att_q;
`endif

endmodule

// File: tb/tb_curl_pow_ctrl.sv
// Directed bench for curl_pow_ctrl with a behavioural Curl core model and a core-write scoreboard.
module tb_curl_pow_ctrl;
  import curl_pow_pkg::*;

  localparam int W = CORE_ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] NC0 = 54'h2A_AAAA_0000_0C01;
  localparam logic [DATA_WIDTH-1:0] NC1 = 54'h15_5555_0000_0C02;
  localparam logic [DATA_WIDTH-1:0] NC2 = 54'h3F_0F0F_0000_0C03;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_start = 1'b0;
  logic [BLK_CNT_WIDTH-1:0] i_num_blocks = '0;
  logic [MWM_WIDTH-1:0] i_mwm = '0;
  logic o_busy, o_done, o_err, o_core_we, o_core_transform, o_core_pow;
  logic [CORE_ADDR_WIDTH-1:0] o_core_addr;
  logic [DATA_WIDTH-1:0] o_core_data, i_core_data;
  logic [MWM_MASK_WIDTH-1:0] o_core_mwm_mask;
  logic i_core_transforming = 1'b0;
  logic i_core_pow_hash_finish = 1'b0;
  logic i_core_pow_finish = 1'b0;
  state_t o_dbg_state;
`ifdef CURL_POW_CTRL_ATTEMPT_CNT_EN
  logic [31:0] o_attempts;
`endif

  curl_pow_ctrl_if strm();

  curl_pow_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_blocks(i_num_blocks), .i_mwm(i_mwm),
    .strm(strm.slave), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_core_we(o_core_we), .o_core_addr(o_core_addr), .o_core_data(o_core_data),
    .o_core_transform(o_core_transform), .o_core_pow(o_core_pow), .o_core_mwm_mask(o_core_mwm_mask),
    .i_core_transforming(i_core_transforming), .i_core_pow_hash_finish(i_core_pow_hash_finish),
    .i_core_pow_finish(i_core_pow_finish), .i_core_data(i_core_data),
`ifdef CURL_POW_CTRL_ATTEMPT_CNT_EN
    .o_attempts(o_attempts),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- core model + monitor ----------------
  logic [DATA_WIDTH-1:0] core_mem [16];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int xform_pulses = 0, pow_pulses = 0, err_pulses = 0, done_pulses = 0, viol = 0;
  int pow_target = 1;
  int xf_cnt = 0, pow_att = 0;
  bit pow_run = 1'b0;

  assign i_core_data = core_mem[o_core_addr];

  initial for (int i = 0; i < 16; i++) core_mem[i] = '0;

  always @(negedge i_clk) begin
    i_core_pow_hash_finish = 1'b0;
    i_core_pow_finish      = 1'b0;
    if (i_rst) begin
      xf_cnt = 0; pow_run = 1'b0; pow_att = 0; i_core_transforming = 1'b0;
    end else begin
      if (o_core_we) begin
        got_q.push_back({o_core_addr, o_core_data});
        core_mem[o_core_addr] = o_core_data;
        if (xf_cnt != 0) viol++;
      end
      // Transform: 2 idle cycles, then busy for 5 cycles.
      if (o_core_transform) begin
        xform_pulses++;
        if (xf_cnt != 0 || o_core_pow) viol++;
        xf_cnt = 7;
      end else if (xf_cnt > 0) xf_cnt--;
      i_core_transforming = (xf_cnt >= 1 && xf_cnt <= 5);
      if (o_core_pow) begin
        pow_pulses++; pow_run = 1'b1; pow_att = 0;
      end else if (pow_run) begin
        pow_att++;
        i_core_pow_hash_finish = 1'b1;
        if (pow_att >= pow_target) begin
          i_core_pow_finish = 1'b1;
          pow_run = 1'b0;
          core_mem[0] = NC0; core_mem[1] = NC1; core_mem[2] = NC2;
        end
      end
      if (o_err)  err_pulses++;
      if (o_done) done_pulses++;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DATA_WIDTH-1:0] mk_word(input int b, input int i);
    return 54'h15_5555_0000_0000 ^ DATA_WIDTH'(b * 256 + i * 7 + 1);
  endfunction

  function automatic bit writes_match(input int g0, input int e0);
    if (got_q.size() - g0 != exp_q.size() - e0) return 1'b0;
    for (int k = 0; k < exp_q.size() - e0; k++)
      if (got_q[g0 + k] !== exp_q[e0 + k]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks (all start and end at posedge+1) ----------------
  task automatic start_job(input int nb, input int mwm);
    i_start = 1'b1; i_num_blocks = BLK_CNT_WIDTH'(nb); i_mwm = MWM_WIDTH'(mwm);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_WIDTH-1:0] w, input bit gap, output bit ok);
    int n = 0;
    if (gap) begin strm.i_s_valid = 1'b0; @(posedge i_clk); #1; end
    strm.i_s_data = w; strm.i_s_valid = 1'b1; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge i_clk);
      if (strm.o_s_ready) ok = 1'b1;
      @(posedge i_clk); #1;
      n++;
    end
    strm.i_s_valid = 1'b0;
  endtask

  task automatic send_blocks(input int nb, input int base_b, input bit gap, output bit ok);
    bit w_ok;
    ok = 1'b1;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        send_word(mk_word(base_b + b, i), gap, w_ok);
        if (!w_ok) begin ok = 1'b0; return; end
        exp_q.push_back({CORE_ADDR_WIDTH'(i), mk_word(base_b + b, i)});
      end
  endtask

  task automatic recv_nonces(output logic [DATA_WIDTH-1:0] w [3], output logic [2:0] lst, output bit ok);
    int n;
    ok = 1'b1; lst = '0;
    for (int k = 0; k < 3; k++) w[k] = '0;
    strm.i_m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge i_clk);
      while (!strm.o_m_valid && n < 5000) begin @(negedge i_clk); n++; end
      if (!strm.o_m_valid) begin ok = 1'b0; strm.i_m_ready = 1'b0; @(posedge i_clk); #1; return; end
      w[k] = strm.o_m_data; lst[k] = strm.o_m_last;
      @(posedge i_clk); #1;
    end
    strm.i_m_ready = 1'b0;
  endtask

  // Samples o_done/o_busy in the cycle after the last nonce and o_done one cycle later.
  task automatic sample_done(output logic d1, output logic b1, output logic d2);
    @(negedge i_clk); d1 = o_done; b1 = o_busy;
    @(posedge i_clk); #1;
    @(negedge i_clk); d2 = o_done;
    @(posedge i_clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    vectors++; if ({strm.o_s_ready, strm.o_m_valid, strm.o_m_last} !== 3'b000) begin
      miscompares++; $display("FAIL reset_stream: got %b want 000", {strm.o_s_ready, strm.o_m_valid, strm.o_m_last}); end
    vectors++; if ({o_core_we, o_core_transform, o_core_pow, o_done, o_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_pulses: got %b want 00000", {o_core_we, o_core_transform, o_core_pow, o_done, o_err}); end
    vectors++; if (o_core_mwm_mask !== 32'h0) begin miscompares++; $display("FAIL reset_mask: got %h want 0", o_core_mwm_mask); end
    vectors++; if (o_dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", o_dbg_state); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_one_block();
    int g0, e0, p0, x0;
    bit ok; logic [DATA_WIDTH-1:0] w [3]; logic [2:0] lst; logic d1, b1, d2;
    g0 = got_q.size(); e0 = exp_q.size(); p0 = pow_pulses; x0 = xform_pulses;
    pow_target = 1;
    start_job(1, 0);
    @(negedge i_clk);
    vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL one_busy: got %b want 1", o_busy); end
    vectors++; if (o_core_mwm_mask !== 32'h0) begin miscompares++; $display("FAIL one_mask: got %h want 0", o_core_mwm_mask); end
    @(posedge i_clk); #1;
    send_blocks(1, 0, 1'b0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL one_send: got timeout=%b want 0", !ok); end
    recv_nonces(w, lst, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL one_recv: got timeout=%b want 0", !ok); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (w[k] !== mk_word(0, 6 + k)) begin
        miscompares++; $display("FAIL one_nonce%0d: got %h want %h", k, w[k], mk_word(0, 6 + k)); end
    end
    vectors++; if (lst !== 3'b100) begin miscompares++; $display("FAIL one_last: got %b want 100", lst); end
    sample_done(d1, b1, d2);
    vectors++; if ({d1, b1, d2} !== 3'b100) begin miscompares++; $display("FAIL one_done: got done/busy/done_next=%b want 100", {d1, b1, d2}); end
    vectors++; if (writes_match(g0, e0) !== 1'b1) begin
      miscompares++; $display("FAIL one_writes: got %0d writes want %0d in order", got_q.size() - g0, exp_q.size() - e0); end
    vectors++; if ({pow_pulses - p0, xform_pulses - x0} !== {32'd1, 32'd0}) begin
      miscompares++; $display("FAIL one_core_pulses: got pow=%0d xform=%0d want pow=1 xform=0", pow_pulses - p0, xform_pulses - x0); end
  endtask

  task automatic test_three_blocks();
    int g0, e0, p0, x0, v0;
    bit ok; logic [DATA_WIDTH-1:0] w [3]; logic [2:0] lst; logic d1, b1, d2;
    g0 = got_q.size(); e0 = exp_q.size(); p0 = pow_pulses; x0 = xform_pulses; v0 = viol;
    pow_target = 4;
    start_job(3, 9);
    @(negedge i_clk);
    vectors++; if (o_core_mwm_mask !== 32'hFF80_0000) begin miscompares++; $display("FAIL three_mask: got %h want ff800000", o_core_mwm_mask); end
    @(posedge i_clk); #1;
    send_blocks(3, 10, 1'b0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL three_send: got timeout=%b want 0", !ok); end
    recv_nonces(w, lst, ok);
    vectors++; if ({w[0], w[1], w[2]} !== {NC0, NC1, NC2}) begin
      miscompares++; $display("FAIL three_nonce: got %h %h %h want %h %h %h", w[0], w[1], w[2], NC0, NC1, NC2); end
    vectors++; if (lst !== 3'b100) begin miscompares++; $display("FAIL three_last: got %b want 100", lst); end
    sample_done(d1, b1, d2);
    vectors++; if ({d1, b1, d2} !== 3'b100) begin miscompares++; $display("FAIL three_done: got %b want 100", {d1, b1, d2}); end
    vectors++; if (xform_pulses - x0 !== 2) begin miscompares++; $display("FAIL three_xforms: got %0d want 2", xform_pulses - x0); end
    vectors++; if (pow_pulses - p0 !== 1) begin miscompares++; $display("FAIL three_pow: got %0d want 1", pow_pulses - p0); end
    vectors++; if (viol - v0 !== 0) begin miscompares++; $display("FAIL three_order: got %0d ordering violations want 0", viol - v0); end
    vectors++; if (writes_match(g0, e0) !== 1'b1) begin
      miscompares++; $display("FAIL three_writes: got %0d writes want %0d in order", got_q.size() - g0, exp_q.size() - e0); end
  endtask

  task automatic test_backpressure();
    int g0, e0, n;
    bit ok; logic [DATA_WIDTH-1:0] w [3]; logic [2:0] lst; logic d1, b1, d2;
    g0 = got_q.size(); e0 = exp_q.size();
    pow_target = 2;
    start_job(2, 32);
    @(negedge i_clk);
    vectors++; if (o_core_mwm_mask !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL bp_mask: got %h want ffffffff", o_core_mwm_mask); end
    @(posedge i_clk); #1;
    send_blocks(2, 20, 1'b1, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL bp_send: got timeout=%b want 0", !ok); end
    strm.i_m_ready = 1'b0;
    n = 0;
    @(negedge i_clk);
    while (!strm.o_m_valid && n < 200) begin @(negedge i_clk); n++; end
    for (int c = 0; c < 5; c++) begin
      vectors++; if ({strm.o_m_valid, strm.o_m_last, strm.o_m_data} !== {1'b1, 1'b0, NC0}) begin
        miscompares++; $display("FAIL bp_hold%0d: got v=%b l=%b d=%h want v=1 l=0 d=%h", c, strm.o_m_valid, strm.o_m_last, strm.o_m_data, NC0); end
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    recv_nonces(w, lst, ok);
    vectors++; if ({w[0], w[1], w[2]} !== {NC0, NC1, NC2}) begin
      miscompares++; $display("FAIL bp_nonce: got %h %h %h want %h %h %h", w[0], w[1], w[2], NC0, NC1, NC2); end
    sample_done(d1, b1, d2);
    vectors++; if ({d1, b1, d2} !== 3'b100) begin miscompares++; $display("FAIL bp_done: got %b want 100", {d1, b1, d2}); end
    vectors++; if (writes_match(g0, e0) !== 1'b1) begin
      miscompares++; $display("FAIL bp_writes: got %0d writes want %0d in order", got_q.size() - g0, exp_q.size() - e0); end
  endtask

  task automatic test_bad_params();
    int nbs [2] = '{0, 1};
    int mwms [2] = '{5, 40};
    int g0, p0, x0;
    for (int t = 0; t < 2; t++) begin
      g0 = got_q.size(); p0 = pow_pulses; x0 = xform_pulses;
      i_start = 1'b1; i_num_blocks = BLK_CNT_WIDTH'(nbs[t]); i_mwm = MWM_WIDTH'(mwms[t]);
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(negedge i_clk);
      vectors++; if ({o_err, o_busy} !== 2'b10) begin
        miscompares++; $display("FAIL bad%0d_err: got err/busy=%b want 10", t, {o_err, o_busy}); end
      @(posedge i_clk); #1;
      @(negedge i_clk);
      vectors++; if ({o_err, o_busy, o_dbg_state} !== {2'b00, ST_IDLE}) begin
        miscompares++; $display("FAIL bad%0d_after: got err=%b busy=%b st=%0d want 0 0 IDLE", t, o_err, o_busy, o_dbg_state); end
      vectors++; if ({got_q.size() - g0, pow_pulses - p0, xform_pulses - x0} !== 96'd0) begin
        miscompares++; $display("FAIL bad%0d_core: got writes=%0d pow=%0d xform=%0d want 0", t, got_q.size() - g0, pow_pulses - p0, xform_pulses - x0); end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset_mid_job();
    int n, e0;
    bit ok; logic [DATA_WIDTH-1:0] w [3]; logic [2:0] lst; logic d1, b1, d2;
    e0 = err_pulses;
    pow_target = 1;
    start_job(2, 3);
    send_blocks(1, 30, 1'b0, ok);
    n = 0;
    @(negedge i_clk);
    while (o_dbg_state != ST_XFORM_WAIT && n < 50) begin @(negedge i_clk); n++; end
    @(posedge i_clk); #1;
    // A bad start outside IDLE must be ignored, not flagged.
    i_start = 1'b1; i_num_blocks = '0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk);
    vectors++; if ({o_err, o_dbg_state} !== {1'b0, ST_XFORM_WAIT}) begin
      miscompares++; $display("FAIL mid_state: got err=%b st=%0d want 0 XFORM_WAIT", o_err, o_dbg_state); end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    vectors++; if ({o_busy, strm.o_s_ready, o_core_transform, o_core_pow, o_core_we, o_done, o_err} !== 7'b0) begin
      miscompares++; $display("FAIL mid_outputs: got %b want 0000000", {o_busy, strm.o_s_ready, o_core_transform, o_core_pow, o_core_we, o_done, o_err}); end
    vectors++; if ({o_core_mwm_mask, o_dbg_state} !== {32'h0, ST_IDLE}) begin
      miscompares++; $display("FAIL mid_idle: got mask=%h st=%0d want 0 IDLE", o_core_mwm_mask, o_dbg_state); end
    vectors++; if (err_pulses - e0 !== 0) begin miscompares++; $display("FAIL mid_err_count: got %0d want 0", err_pulses - e0); end
    @(posedge i_clk); #1;
    start_job(1, 0);
    send_blocks(1, 40, 1'b0, ok);
    recv_nonces(w, lst, ok);
    vectors++; if ({w[0], w[1], w[2]} !== {mk_word(40, 6), mk_word(40, 7), mk_word(40, 8)}) begin
      miscompares++; $display("FAIL mid_restart_nonce: got %h %h %h want %h %h %h", w[0], w[1], w[2], mk_word(40, 6), mk_word(40, 7), mk_word(40, 8)); end
    sample_done(d1, b1, d2);
    vectors++; if ({d1, b1, d2} !== 3'b100) begin miscompares++; $display("FAIL mid_restart_done: got %b want 100", {d1, b1, d2}); end
  endtask

`ifdef CURL_POW_CTRL_ATTEMPT_CNT_EN
  task automatic test_attempt_count();
    bit ok; logic [DATA_WIDTH-1:0] w [3]; logic [2:0] lst; logic d1, b1, d2;
    pow_target = 1001;
    start_job(1, 12);
    @(negedge i_clk);
    vectors++; if (o_attempts !== 32'd0) begin miscompares++; $display("FAIL att_clear: got %0d want 0", o_attempts); end
    @(posedge i_clk); #1;
    send_blocks(1, 50, 1'b0, ok);
    recv_nonces(w, lst, ok);
    vectors++; if ({w[0], w[1], w[2]} !== {NC0, NC1, NC2}) begin
      miscompares++; $display("FAIL att_nonce: got %h %h %h want %h %h %h", w[0], w[1], w[2], NC0, NC1, NC2); end
    sample_done(d1, b1, d2);
    vectors++; if (o_attempts !== 32'd1001) begin miscompares++; $display("FAIL att_count: got %0d want 1001", o_attempts); end
  endtask
`endif

  initial begin
    strm.i_s_data = '0; strm.i_s_valid = 1'b0; strm.i_m_ready = 1'b0;
    test_reset();
    test_one_block();
    test_three_blocks();
    test_backpressure();
    test_bad_params();
    test_reset_mid_job();
`ifdef CURL_POW_CTRL_ATTEMPT_CNT_EN
    test_attempt_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/curl_pow_ctrl.md
Name: curl_pow_ctrl

Overview:
Job sequencer in front of the Curl PoW core.
- Accepts a transaction as a stream of 54-bit words (27 trits each, 2 bits per trit), 9 words per 243-trit block.
- Writes each block into the core's low state third, then pulses transform for every block except the last.
- On the last block, launches PoW with a mask derived from MWM.
- Returns the 3 winning nonce words on an output stream.
- Sits between the HPS-facing bridge/FIFO and the core.

Parameters:
DATA_WIDTH, 54, word width (27 trits)
WORDS_PER_BLOCK, 9, words written per absorbed block
NONCE_WORDS, 3, nonce words returned (block words 6..8)
BLK_CNT_WIDTH, 4, width of block count (1..15 blocks)
MWM_WIDTH, 6, width of MWM input (0..32)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  job start pulse; sampled in IDLE only
i_num_blocks  in  BLK_CNT_WIDTH  blocks in job; sampled at start
i_mwm  in  MWM_WIDTH  minimum weight magnitude; sampled at start
i_s_data  in  DATA_WIDTH  input word stream data
i_s_valid  in  1  input word valid
o_s_ready  out  1  input word ready
o_m_data  out  DATA_WIDTH  nonce word out
o_m_valid  out  1  nonce word valid
o_m_last  out  1  third nonce word
i_m_ready  in  1  nonce sink ready
o_busy  out  1  job in progress
o_done  out  1  one-cycle job-complete pulse
o_err  out  1  one-cycle pulse: start with i_num_blocks==0 or i_mwm>32
o_core_we  out  1  core word write enable
o_core_addr  out  4  core word address (0..8)
o_core_data  out  DATA_WIDTH  core write data
o_core_transform  out  1  core transform pulse
o_core_pow  out  1  core PoW pulse
o_core_mwm_mask  out  32  core MWM mask
i_core_transforming  in  1  core transform busy
i_core_pow_hash_finish  in  1  core per-attempt hash-done pulse
i_core_pow_finish  in  1  core valid-nonce pulse
i_core_data  in  DATA_WIDTH  core nonce word at o_core_addr (combinational)

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared.
- Reset mid-job: abandons the job without waiting; core is not reset by this block (system must reset the core alongside).
- Start in IDLE:
  - Bad parameters → o_err pulse next cycle; stay IDLE.
  - Otherwise latch blocks and mask, where o_core_mwm_mask = ~(32'hFFFFFFFF >> mwm) (mwm=0 → 0, mwm=32 → all ones); mask is held stable until IDLE.
  - Go to LOAD with o_busy=1.
- i_start outside IDLE: ignored.
- LOAD:
  - o_s_ready=1; each valid&ready beat sets o_core_we=1, o_core_addr=word_cnt, o_core_data=i_s_data in the same cycle.
  - word_cnt 0..8 wraps to 0.
  - On the last block, words 6..8 are also captured into nonce_cap[0..2].
  - After word 8: if blk_cnt is not the last block → XFORM_REQ, else → POW_REQ.
- XFORM_REQ: o_core_transform=1 for 1 cycle; o_s_ready=0 → XFORM_WAIT.
- XFORM_WAIT:
  - Set seen_busy when i_core_transforming=1.
  - Exit to LOAD (blk_cnt+1) when seen_busy && !i_core_transforming.
  - Transform latency is not assumed (core: 81 rounds).
- POW_REQ: o_core_pow=1 for 1 cycle; o_core_transform never asserted simultaneously → POW_WAIT.
- POW_WAIT:
  - Each i_core_pow_hash_finish increments the attempt count (saturating at 2 without the feature).
  - i_core_pow_finish → NONCE_OUT, idx=0.
- NONCE_OUT:
  - o_m_valid=1, o_core_addr=idx.
  - o_m_data = nonce_cap[idx] if attempts==1 (the first attempt used host nonce words), else i_core_data.
  - o_m_data is held stable while valid && !ready.
  - Advance idx on i_m_ready; o_m_last at idx=2; the accepted last word → IDLE, o_done=1 for 1 cycle, o_busy=0 the same cycle.
- i_core_pow_finish outside POW_WAIT: ignored.

Optional Feature:
Macro CURL_POW_CTRL_ATTEMPT_CNT_EN.
- Defined: adds output o_attempts (32 bits): full attempt counter, saturating at 32'hFFFFFFFF, cleared at accepted start, held after done until the next start.
- Undefined: port absent; internal counter is a 2-bit saturating counter used only for the nonce source select.

Decomposition:
- Package curl_pow_pkg: DATA_WIDTH, WORDS_PER_BLOCK, NONCE_WORD_OFFSET=6, NONCE_WORDS, MWM_MASK_WIDTH=32, state enum typedef.
- No sub-module is needed; the mask generator is a package function mwm_to_mask.

Test Plan:
- 1 block, mwm=0: 9 words, then o_core_pow, core model finishes on attempt 1 → o_m_data equals input words 6,7,8; o_m_last on the 3rd; o_done 1 cycle.
- 3 blocks, mwm=9: exactly 2 transform pulses, each issued only after the prior transforming fall; mask=32'hFF800000; finish on attempt 4 → nonces read from core addr 0..2.
- Backpressure: i_s_valid toggled each cycle, i_m_ready low 5 cycles → no dropped or duplicated core writes; o_m_data held stable.
- i_num_blocks=0, or i_mwm=40 → o_err pulse; no core activity; o_busy stays 0.
- i_rst asserted in XFORM_WAIT → next cycle all outputs 0, IDLE; new start accepted.
- Feature on: 1000 failing attempts then finish → o_attempts=1001.
